sumador_serial_ctrl: RTL and testbench

Bit-serial N-bit adder controller built around the team's 1-bit full-adder cell `sumador` (A, B, Ci → S, Co). It latches two WIDTH-bit operands and a carry-in on a start request, then feeds the cell one bit pair per clock, LSB first, keeping the carry in a register between bits. When WIDTH bits are done it presents the WIDTH-bit sum and carry-out with a one-cycle done pulse. It sits between a requesting unit and the single shared 1-bit adder cell, trading latency for area.

---
 rtl/sumador_serial_ctrl.sv | 118 +++++++++++
 tb/tb_sumador_serial_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/sumador_serial_ctrl.sv
// ----------------------------------------------------------------------------
// sumador            : 1-bit full-adder cell (A, B, Ci -> S, Co).
// sumador_serial_ctrl: bit-serial WIDTH-bit adder built on one sumador cell.
//   Latches a, b and ci when start is seen in IDLE. It then feeds the cell one
//   bit pair per clock, LSB first, and keeps the carry in a register between
//   bits. After WIDTH bits it updates {co, sum} and pulses done for one cycle.
//
// Ports (sumador_serial_ctrl):
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   start  in   request, sampled only in IDLE
//   a, b   in   WIDTH-bit operands, sampled on the accepting edge
//   ci     in   carry-in, sampled on the accepting edge
//   busy   out  high while an addition is in progress
//   done   out  one-cycle pulse, sum/co just updated
//   sum    out  WIDTH-bit result of the last completed addition (held)
//   co     out  carry-out of the last completed addition (held)
// ----------------------------------------------------------------------------
module sumador (
  input  logic A,
  input  logic B,
  input  logic Ci,
  output logic S,
  output logic Co
);
  assign S  = A ^ B ^ Ci;
  assign Co = (A & B) | (Ci & (A ^ B));
endmodule

module sumador_serial_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             co
);
  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, RUN} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] sa_q, sb_q, ss_q, sum_q;
  logic             c_q, co_q, busy_q, done_q;
  logic [CW-1:0]    cnt_q;

  logic             s_bit, co_bit;
  logic [WIDTH-1:0] ss_d;

  // The only adder in the design: current LSBs plus the stored carry.
  sumador u_cell (
    .A  (sa_q[0]),
    .B  (sb_q[0]),
    .Ci (c_q),
    .S  (s_bit),
    .Co (co_bit)
  );

  // {S, ss[WIDTH-1:1]}, written as shift+or so that WIDTH=1 needs no special case.
  assign ss_d = (ss_q >> 1) | (WIDTH'(s_bit) << (WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      ss_q    <= '0;
      sum_q   <= '0;
      c_q     <= 1'b0;
      co_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            sa_q    <= a;
            sb_q    <= b;
            c_q     <= ci;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          sa_q  <= sa_q >> 1;
          sb_q  <= sb_q >> 1;
          ss_q  <= ss_d;
          c_q   <= co_bit;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            sum_q   <= ss_d;
            co_q    <= co_bit;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign co   = co_q;

endmodule

// File: tb/tb_sumador_serial_ctrl.sv
module tb_sumador_serial_ctrl;
  localparam int unsigned W8 = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // WIDTH=8 instance
  logic       start8 = 1'b0, ci8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, co8;
  logic [7:0] sum8;

  // WIDTH=1 instance
  logic start1 = 1'b0, a1 = 1'b0, b1 = 1'b0, ci1 = 1'b0;
  logic busy1, done1, sum1, co1;

  sumador_serial_ctrl #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .ci(ci8),
    .busy(busy8), .done(done8), .sum(sum8), .co(co8)
  );

  sumador_serial_ctrl #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .ci(ci1),
    .busy(busy1), .done(done1), .sum(sum1), .co(co1)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 1'b0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: an accepted request finishes WIDTH edges later
  // with {co,sum} = a + b + ci; requests while busy are dropped.
  int         m8_rem;
  logic       m8_busy, m8_done, m8_co;
  logic [7:0] m8_sum;
  logic [8:0] m8_pend;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m8_rem <= 0; m8_busy <= 1'b0; m8_done <= 1'b0;
      m8_sum <= '0; m8_co <= 1'b0; m8_pend <= '0;
    end else begin
      m8_done <= 1'b0;
      if (!m8_busy) begin
        if (start8) begin
          m8_busy <= 1'b1;
          m8_rem  <= W8;
          m8_pend <= {1'b0, a8} + {1'b0, b8} + 9'(ci8);
        end
      end else begin
        m8_rem <= m8_rem - 1;
        if (m8_rem == 1) begin
          m8_busy <= 1'b0;
          m8_done <= 1'b1;
          {m8_co, m8_sum} <= m8_pend;
        end
      end
    end
  end

  int         m1_rem;
  logic       m1_busy, m1_done, m1_co, m1_sum;
  logic [1:0] m1_pend;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m1_rem <= 0; m1_busy <= 1'b0; m1_done <= 1'b0;
      m1_sum <= 1'b0; m1_co <= 1'b0; m1_pend <= '0;
    end else begin
      m1_done <= 1'b0;
      if (!m1_busy) begin
        if (start1) begin
          m1_busy <= 1'b1;
          m1_rem  <= 1;
          m1_pend <= 2'(a1) + 2'(b1) + 2'(ci1);
        end
      end else begin
        m1_rem <= m1_rem - 1;
        if (m1_rem == 1) begin
          m1_busy <= 1'b0;
          m1_done <= 1'b1;
          {m1_co, m1_sum} <= m1_pend;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("busy8", busy8, m8_busy);
      chk("done8", done8, m8_done);
      chk("sum8",  sum8,  m8_sum);
      chk("co8",   co8,   m8_co);
      chk("busy1", busy1, m1_busy);
      chk("done1", done1, m1_done);
      chk("sum1",  sum1,  m1_sum);
      chk("co1",   co1,   m1_co);
    end
  end

  task automatic go8(input logic [7:0] a, input logic [7:0] b, input logic c);
    @(negedge clk);
    start8 = 1'b1; a8 = a; b8 = b; ci8 = c;
    @(negedge clk);
    start8 = 1'b0;
  endtask

  // Returns the number of negedges waited until done8 is seen (bounded).
  task automatic wait8(output int lat);
    lat = 0;
    while (!done8 && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    if (!done8) chk("done8_timeout", done8, 1);
  endtask

  task automatic op8(input string nm, input logic [7:0] a, input logic [7:0] b,
                     input logic c, input logic [7:0] es, input logic eco);
    int lat;
    go8(a, b, c);
    wait8(lat);
    chk({nm, "_lat"}, lat, W8);
    chk({nm, "_sum"}, sum8, es);
    chk({nm, "_co"}, co8, eco);
    chk({nm, "_model_sum"}, m8_sum, es);
    chk({nm, "_model_co"}, m8_co, eco);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, cnt, prev;
    logic [8:0] exp9;
    logic [1:0] e2;

    repeat (3) @(negedge clk);
    chk("rst_busy", busy8, 0);
    chk("rst_done", done8, 0);
    chk("rst_sum",  sum8,  0);
    chk("rst_co",   co8,   0);
    cmp_en = 1'b1;
    rst_n  = 1'b1;

    op8("add5a3c", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
    op8("ffp01",   8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    op8("ffp00c1", 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1);

    // Start pulsed while busy must be dropped.
    go8(8'h11, 8'h22, 1'b0);
    repeat (2) @(negedge clk);
    start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; ci8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    wait8(lat);
    chk("ign_sum", sum8, 8'h33);
    chk("ign_co",  co8,  1'b0);
    cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8) cnt++;
    end
    chk("ign_extra_done", cnt, 0);

    // Reset in the middle of a run aborts it at once.
    go8(8'h5A, 8'h3C, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", busy8, 0);
    chk("abort_done", done8, 0);
    chk("abort_sum",  sum8,  0);
    chk("abort_co",   co8,   0);
    @(negedge clk);
    rst_n = 1'b1;
    op8("add8080", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1);

    // WIDTH=1: full truth table, done one cycle after acceptance.
    for (int v = 0; v < 8; v++) begin
      @(negedge clk);
      start1 = 1'b1; a1 = v[2]; b1 = v[1]; ci1 = v[0];
      e2 = 2'(a1) + 2'(b1) + 2'(ci1);
      @(negedge clk);
      start1 = 1'b0;
      lat = 0;
      while (!done1 && lat < 10) begin
        @(negedge clk);
        lat++;
      end
      chk("w1_lat", lat, 1);
      chk("w1_res", {co1, sum1}, e2);
      if (v == 3) begin
        chk("w1_011_sum", sum1, 1'b0);
        chk("w1_011_co",  co1,  1'b1);
      end
    end

    // start held high: the done cycle is the IDLE cycle that accepts the next
    // request, so completions are WIDTH+1 edges apart.
    @(negedge clk);
    a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom);
    exp9 = {1'b0, a8} + {1'b0, b8} + 9'(ci8);
    start8 = 1'b1;
    prev = -1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      wait8(lat);
      chk("b2b_res", {co8, sum8}, exp9);
      if (prev >= 0) chk("b2b_spacing", cyc - prev, W8 + 1);
      prev = cyc;
      a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom);
      exp9 = {1'b0, a8} + {1'b0, b8} + 9'(ci8);
    end
    start8 = 1'b0;
    repeat (12) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
